scr_1dim_core: RTL and testbench
================================

SCR_1DIM_CORE -- requirements
Module: scr_1dim_core

Interface
REQ-001 Parameter DATA_WIDTH, default 1: bits scrambled per enabled cycle, legal range 1..SCR_WIDTH.
REQ-002 Parameter SCR_WIDTH, default 7: LFSR state width, minimum 4.
REQ-003 Parameter TAP_B, default SCR_WIDTH-4 (3): second feedback tap index, legal range 0..SCR_WIDTH-2.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 kill  input  1  reset, synchronous and active-high.
REQ-006 scr_en  input  1  1 = scramble data; 0 = bypass (data passes unmodified).
REQ-007 data_in  input  DATA_WIDTH  input data word.
REQ-008 data_in_en  input  1  data_in valid; advances the LFSR.
REQ-009 init_val  input  SCR_WIDTH  LFSR seed.
REQ-010 init_val_en  input  1  seed load strobe.
REQ-011 data_out  output  DATA_WIDTH  registered scrambled or bypassed data.
REQ-012 data_out_en  output  1  data_out valid.

Function
REQ-013 One LFSR step from state s SHALL compute fb = s[SCR_WIDTH-1] XOR s[TAP_B]; the next state SHALL be {s[SCR_WIDTH-2:0], fb}, i.e. shift left with fb entering bit 0.
REQ-014 The default configuration SHALL implement polynomial x^7+x^4+1.
REQ-015 The effective start state for a cycle SHALL be s0 = init_val when init_val_en=1, otherwise the internal state register.
REQ-016 Data bits SHALL be processed MSB first: for k=0..DATA_WIDTH-1, bit DATA_WIDTH-1-k uses fb(s_k), and s_{k+1} is the LFSR step applied to s_k.
REQ-017 On a cycle with data_in_en=1, the state register SHALL become s_DATA_WIDTH, i.e. DATA_WIDTH steps from s0, regardless of scr_en.
REQ-018 On a cycle with data_in_en=0 and init_val_en=1, the state register SHALL load init_val without stepping.
REQ-019 On a cycle with data_in_en=0 and init_val_en=0, the state register SHALL hold.
REQ-020 On a cycle with data_in_en=1, data_out SHALL register data_in XOR keystream when scr_en=1, and data_in unchanged when scr_en=0.
REQ-021 On a cycle with data_in_en=0, data_out SHALL hold its previous value.
REQ-022 data_out_en SHALL register data_in_en; latency is one clock from input to output.
REQ-023 An all-zero seed SHALL be accepted without correction; the keystream is then 0 and the state stays 0.

Reset
REQ-024 When kill=1 at a rising edge: state SHALL become all ones, data_out 0, data_out_en 0.
REQ-025 kill SHALL take priority over init_val_en and data_in_en in the same cycle.
REQ-026 Normal operation SHALL resume on the first edge with kill=0.

Verification
REQ-027 Seed load + reset: init_val=7'h7F with init_val_en=1, then kill=1 for one cycle -> state 7'h7F, data_out=0, data_out_en=0.
REQ-028 Shift sequence: load seed 7'h01, then data_in_en=1, init_val_en=0, scr_en=0 for 6 cycles -> state sequence 02,04,08,11,22,44, then 09.
REQ-029 Bypass: scr_en=0, init_val_en=1, init_val=7'h40, data_in 0 then 1 -> data_out 0 then 1 one cycle later, with data_out_en=1.
REQ-030 Scramble with zero keystream: scr_en=1, init_val_en=1, init_val=0, data_in 0 then 1 -> data_out 0 then 1.
REQ-031 Scramble with fb=1: scr_en=1, init_val_en=1, init_val=7'h40, data_in 0 then 1 -> data_out 1 then 0.
REQ-032 Priority: kill=1 asserted together with init_val_en=1 and data_in_en=1 -> reset values are taken and the seed is ignored.

Source files
------------

// File: rtl/scr_1dim_core.sv
// Parallel additive LFSR scrambler with seed load and bypass.
// Each enabled cycle consumes DATA_WIDTH bits MSB first; output is registered.
module scr_1dim_core #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned SCR_WIDTH  = 7,
  parameter int unsigned TAP_B      = SCR_WIDTH - 4
) (
  input  logic                  clk,
  input  logic                  kill,
  input  logic                  scr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_en,
  input  logic [SCR_WIDTH-1:0]  init_val,
  input  logic                  init_val_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_en
);

  logic [SCR_WIDTH-1:0]  state_q;
  logic [SCR_WIDTH-1:0]  state_d;
  logic [SCR_WIDTH-1:0]  walk;
  logic [DATA_WIDTH-1:0] keystream;

  // Unroll DATA_WIDTH LFSR steps from the effective start state; the seed
  // bypasses the register so a word can be scrambled on the load cycle.
  always_comb begin
    walk      = init_val_en ? init_val : state_q;
    keystream = '0;
    for (int k = 0; k < int'(DATA_WIDTH); k++) begin
      keystream[DATA_WIDTH-1-k] = walk[SCR_WIDTH-1] ^ walk[TAP_B];
      walk = {walk[SCR_WIDTH-2:0], walk[SCR_WIDTH-1] ^ walk[TAP_B]};
    end
  end

  always_comb begin
    state_d = state_q;
    if (data_in_en) begin
      state_d = walk;
    end else if (init_val_en) begin
      state_d = init_val;
    end
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      state_q     <= '1;
      data_out    <= '0;
      data_out_en <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_out_en <= data_in_en;
      if (data_in_en) begin
        data_out <= scr_en ? (data_in ^ keystream) : data_in;
      end
    end
  end

endmodule

// File: tb/tb_scr_1dim_core.sv
// Scoreboard bench: two scrambler instances (1-bit and 4-bit words) against
// a reference model of the x^7+x^4+1 keystream.
module tb_scr_1dim_core;

  logic       clk = 1'b0;
  logic       kill = 1'b1;
  logic       scr_en = 1'b0;
  logic       data_in_en = 1'b0;
  logic [0:0] data_in1 = '0;
  logic [3:0] data_in4 = '0;
  logic [6:0] init_val = '0;
  logic       init_val_en = 1'b0;
  logic [0:0] data_out1;
  logic [3:0] data_out4;
  logic       data_out_en1;
  logic       data_out_en4;

  always #5 clk = ~clk;

  scr_1dim_core dut1 (
    .clk         (clk),
    .kill        (kill),
    .scr_en      (scr_en),
    .data_in     (data_in1),
    .data_in_en  (data_in_en),
    .init_val    (init_val),
    .init_val_en (init_val_en),
    .data_out    (data_out1),
    .data_out_en (data_out_en1)
  );

  scr_1dim_core #(.DATA_WIDTH(4)) dut4 (
    .clk         (clk),
    .kill        (kill),
    .scr_en      (scr_en),
    .data_in     (data_in4),
    .data_in_en  (data_in_en),
    .init_val    (init_val),
    .init_val_en (init_val_en),
    .data_out    (data_out4),
    .data_out_en (data_out_en4)
  );

  typedef struct {
    int         due;
    logic [6:0] st1;
    logic [6:0] st4;
    logic [0:0] o1;
    logic [3:0] o4;
    logic       en;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  // Reference model state
  logic [6:0] m_st1, m_st4;
  logic [0:0] m_o1;
  logic [3:0] m_o4;
  logic       m_en;

  always @(posedge clk) cyc <= cyc + 1;

  // x^7 + x^4 + 1: feedback from bit 6 and bit 3, shift left.
  function automatic logic [6:0] lfsr_next(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[3]};
  endfunction

  function automatic logic lfsr_fb(input logic [6:0] s);
    return s[6] ^ s[3];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic drive(input logic k, input logic s, input logic de, input logic [0:0] d1,
                       input logic [3:0] d4, input logic [6:0] iv, input logic ie);
    exp_t       e;
    logic [6:0] w;
    logic [3:0] ks4;
    logic [0:0] ks1;
    @(posedge clk);
    #1;
    kill = k; scr_en = s; data_in_en = de; data_in1 = d1; data_in4 = d4;
    init_val = iv; init_val_en = ie;
    if (k) begin
      m_st1 = 7'h7F; m_st4 = 7'h7F; m_o1 = '0; m_o4 = '0; m_en = 1'b0;
    end else begin
      m_en = de;
      if (de) begin
        w = ie ? iv : m_st1;
        ks1[0] = lfsr_fb(w);
        m_st1 = lfsr_next(w);
        m_o1 = s ? (d1 ^ ks1) : d1;
        w = ie ? iv : m_st4;
        for (int i = 3; i >= 0; i--) begin
          ks4[i] = lfsr_fb(w);
          w = lfsr_next(w);
        end
        m_st4 = w;
        m_o4 = s ? (d4 ^ ks4) : d4;
      end else if (ie) begin
        m_st1 = iv;
        m_st4 = iv;
      end
    end
    e.due = cyc + 1;
    e.st1 = m_st1; e.st4 = m_st4; e.o1 = m_o1; e.o4 = m_o4; e.en = m_en;
    sb.push_back(e);
  endtask

  // Monitor: compares every due expectation away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("data_out_w1", 32'(data_out1), 32'(e.o1));
        check("data_out_w4", 32'(data_out4), 32'(e.o4));
        check("data_out_en_w1", 32'(data_out_en1), 32'(e.en));
        check("data_out_en_w4", 32'(data_out_en4), 32'(e.en));
        check("state_w1", 32'(dut1.state_q), 32'(e.st1));
        check("state_w4", 32'(dut4.state_q), 32'(e.st4));
      end
    end
  end

  initial begin
    logic k, s, de, ie;
    // Initial reset
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 7'h00, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 7'h00, 1'b0);
    // Seed load then reset
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 7'h7F, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 7'h00, 1'b0);
    // Shift sequence from seed 01: 02,04,08,11,22,44,09
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 7'h01, 1'b1);
    for (int i = 0; i < 7; i++)
      drive(1'b0, 1'b0, 1'b1, 1'($urandom), 4'($urandom), 7'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 7'h00, 1'b0);
    // Bypass with seed 40
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 7'h40, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 7'h40, 1'b1);
    // Zero seed: keystream stays 0
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 7'h00, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'hA, 7'h00, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 7'h00, 1'b0);
    // Seed 40 gives fb=1 on the first bit
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 7'h40, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 7'h40, 1'b1);
    // Hold of data_out when idle
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 7'h00, 1'b0);
    // Kill beats seed load and data
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'hC, 7'h55, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h6, 7'h00, 1'b0);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      k  = ($urandom_range(49) == 0);
      s  = 1'($urandom);
      de = ($urandom_range(3) != 0);
      ie = ($urandom_range(7) == 0);
      drive(k, s, de, 1'($urandom), 4'($urandom), 7'($urandom), ie);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 7'h00, 1'b0);
    // Bounded drain of the scoreboard
    repeat (4) @(posedge clk);
    #2;
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
